// File: rtl/pwc_pkg.sv
// Shared types and helpers for the pulse width checker.
package pwc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LONG = 2'd2
   } pwc_state_e;

   localparam int PWC_PW_MIN_DEF = 16;
   localparam int PWC_PW_MAX_DEF = 16;
   localparam int PWC_CNT_W_DEF  = 8;

   // Increment that holds at the all-ones value of a width-bit field.
   function automatic logic [31:0] pwc_sat_inc(input logic [31:0] val,
                                               input int unsigned width);
      logic [31:0] lim;
      lim = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (val >= lim) ? lim : (val + 32'd1);
   endfunction

endpackage

// File: rtl/pwc_chan.sv
// One channel of the pulse width checker: FSM, width counter, error counter.
// Sticky error flags exist only when PWC_STICKY_EN is defined.
module pwc_chan
   import pwc_pkg::*;
#(
   parameter int PW_MIN = PWC_PW_MIN_DEF,
   parameter int PW_MAX = PWC_PW_MAX_DEF,
   parameter int CNT_W  = PWC_CNT_W_DEF,
   parameter int WID_W  = $clog2(PW_MAX + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             chan_en_i,
   input  logic             sticky_clr_i,
   output logic             ok_o,
   output logic             short_err_o,
   output logic             long_err_o,
   output logic [WID_W-1:0] last_wid_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             sticky_short_o,
   output logic             sticky_long_o
);

   localparam logic [WID_W-1:0] LIM  = WID_W'(PW_MAX + 1);
   localparam logic [WID_W-1:0] MINV = WID_W'(PW_MIN);

   pwc_state_e       r_state;
   pwc_state_e       w_state_nxt;
   logic [WID_W-1:0] r_cnt;
   logic [WID_W-1:0] w_cnt_nxt;
   logic [WID_W-1:0] w_cnt_inc;
   logic             r_prev;

   logic             w_ok_nxt;
   logic             w_short_nxt;
   logic             w_long_nxt;
   logic             w_wid_ld;
   logic [WID_W-1:0] w_wid_nxt;

   logic             r_ok;
   logic             r_short;
   logic             r_long;
   logic [WID_W-1:0] r_wid;
   logic [CNT_W-1:0] r_err_cnt;

   assign w_cnt_inc = r_cnt + WID_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_prev  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_prev  <= en_i;
      end
   end

   // Disabling the channel abandons any pulse in flight without a report.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ok_nxt    = 1'b0;
      w_short_nxt = 1'b0;
      w_long_nxt  = 1'b0;
      w_wid_ld    = 1'b0;
      w_wid_nxt   = r_cnt;
      if (!chan_en_i) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!r_prev && en_i) begin
                  w_state_nxt = HIGH;
                  w_cnt_nxt   = WID_W'(1);
               end
            end
            HIGH: begin
               if (en_i) begin
                  if (w_cnt_inc == LIM) begin
                     w_long_nxt  = 1'b1;
                     w_wid_ld    = 1'b1;
                     w_wid_nxt   = LIM;
                     w_state_nxt = LONG;
                  end
                  w_cnt_nxt = w_cnt_inc;
               end else begin
                  if (r_cnt < MINV) begin
                     w_short_nxt = 1'b1;
                  end else begin
                     w_ok_nxt = 1'b1;
                  end
                  w_wid_ld    = 1'b1;
                  w_wid_nxt   = r_cnt;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            LONG: begin
               if (!en_i) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ok      <= 1'b0;
         r_short   <= 1'b0;
         r_long    <= 1'b0;
         r_wid     <= '0;
         r_err_cnt <= '0;
      end else begin
         r_ok    <= w_ok_nxt;
         r_short <= w_short_nxt;
         r_long  <= w_long_nxt;
         if (w_wid_ld) begin
            r_wid <= w_wid_nxt;
         end
         if (w_short_nxt || w_long_nxt) begin
            r_err_cnt <= CNT_W'(pwc_sat_inc(32'(r_err_cnt), CNT_W));
         end
      end
   end

`ifdef PWC_STICKY_EN
   logic r_sticky_short;
   logic r_sticky_long;

   // A new error on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky_short <= 1'b0;
         r_sticky_long  <= 1'b0;
      end else begin
         if (w_short_nxt) begin
            r_sticky_short <= 1'b1;
         end else if (sticky_clr_i) begin
            r_sticky_short <= 1'b0;
         end
         if (w_long_nxt) begin
            r_sticky_long <= 1'b1;
         end else if (sticky_clr_i) begin
            r_sticky_long <= 1'b0;
         end
      end
   end

   assign sticky_short_o = r_sticky_short;
   assign sticky_long_o  = r_sticky_long;
`else
   logic w_unused_clr;
   assign w_unused_clr   = sticky_clr_i;
   assign sticky_short_o = 1'b0;
   assign sticky_long_o  = 1'b0;
`endif

   assign ok_o        = r_ok;
   assign short_err_o = r_short;
   assign long_err_o  = r_long;
   assign last_wid_o  = r_wid;
   assign err_cnt_o   = r_err_cnt;

endmodule

// File: rtl/pulse_width_checker.sv
// Multi-channel pulse width checker: NCH independent pwc_chan instances.
// Optional sticky error flags are built when PWC_STICKY_EN is defined.
module pulse_width_checker
   import pwc_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int PW_MIN = PWC_PW_MIN_DEF,
   parameter int PW_MAX = PWC_PW_MAX_DEF,
   parameter int CNT_W  = PWC_CNT_W_DEF,
   localparam int WID_W = $clog2(PW_MAX + 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en_i,
   input  logic [NCH-1:0]       chan_en_i,
   output logic [NCH-1:0]       ok_o,
   output logic [NCH-1:0]       short_err_o,
   output logic [NCH-1:0]       long_err_o,
   output logic [NCH*WID_W-1:0] last_wid_o,
   output logic [NCH*CNT_W-1:0] err_cnt_o,
   input  logic [NCH-1:0]       sticky_clr_i,
   output logic [NCH-1:0]       sticky_short_o,
   output logic [NCH-1:0]       sticky_long_o
);

   genvar c;
   generate
      for (c = 0; c < NCH; c++) begin : g_chan
         pwc_chan #(
            .PW_MIN (PW_MIN),
            .PW_MAX (PW_MAX),
            .CNT_W  (CNT_W),
            .WID_W  (WID_W)
         ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .en_i           (en_i[c]),
            .chan_en_i      (chan_en_i[c]),
            .sticky_clr_i   (sticky_clr_i[c]),
            .ok_o           (ok_o[c]),
            .short_err_o    (short_err_o[c]),
            .long_err_o     (long_err_o[c]),
            .last_wid_o     (last_wid_o[c*WID_W +: WID_W]),
            .err_cnt_o      (err_cnt_o[c*CNT_W +: CNT_W]),
            .sticky_short_o (sticky_short_o[c]),
            .sticky_long_o  (sticky_long_o[c])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pulse_width_checker.sv
// Bench for pulse_width_checker: run-length reference model checked every
// cycle, plus directed literal checks. Honours PWC_STICKY_EN if defined.
module tb_pulse_width_checker;

   localparam int NCH    = 4;
   localparam int PW_MIN = 16;
   localparam int PW_MAX = 16;
   localparam int CNT_W  = 8;
   localparam int WID_W  = $clog2(PW_MAX + 2);
`ifdef PWC_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       en_i;
   logic [NCH-1:0]       chan_en_i;
   logic [NCH-1:0]       ok_o;
   logic [NCH-1:0]       short_err_o;
   logic [NCH-1:0]       long_err_o;
   logic [NCH*WID_W-1:0] last_wid_o;
   logic [NCH*CNT_W-1:0] err_cnt_o;
   logic [NCH-1:0]       sticky_clr_i;
   logic [NCH-1:0]       sticky_short_o;
   logic [NCH-1:0]       sticky_long_o;

   int n_vec = 0;
   int n_err = 0;

   pulse_width_checker #(
      .NCH    (NCH),
      .PW_MIN (PW_MIN),
      .PW_MAX (PW_MAX),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en_i           (en_i),
      .chan_en_i      (chan_en_i),
      .ok_o           (ok_o),
      .short_err_o    (short_err_o),
      .long_err_o     (long_err_o),
      .last_wid_o     (last_wid_o),
      .err_cnt_o      (err_cnt_o),
      .sticky_clr_i   (sticky_clr_i),
      .sticky_short_o (sticky_short_o),
      .sticky_long_o  (sticky_long_o)
   );

   always #5 clk = ~clk;

   // Reference model: length of the current high run per channel (0 = not tracking).
   int             m_run  [NCH];
   bit             m_prev [NCH];
   int             e_wid  [NCH];
   int             e_cnt  [NCH];
   logic [NCH-1:0] e_ok, e_sh, e_lg, e_ss, e_sl;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c]  = 0;
         m_prev[c] = 1'b1;
         e_wid[c]  = 0;
         e_cnt[c]  = 0;
      end
      e_ok = '0; e_sh = '0; e_lg = '0; e_ss = '0; e_sl = '0;
   endtask

   initial model_reset();

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < NCH; c++) begin
            e_ok[c] = 1'b0;
            e_sh[c] = 1'b0;
            e_lg[c] = 1'b0;
            if (!chan_en_i[c]) begin
               m_run[c] = 0;
            end else if (m_run[c] > 0) begin
               if (en_i[c]) begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] == PW_MAX + 1) begin
                     e_lg[c]  = 1'b1;
                     e_wid[c] = PW_MAX + 1;
                  end
               end else begin
                  if (m_run[c] <= PW_MAX) begin
                     if (m_run[c] < PW_MIN) e_sh[c] = 1'b1;
                     else                   e_ok[c] = 1'b1;
                     e_wid[c] = m_run[c];
                  end
                  m_run[c] = 0;
               end
            end else if (en_i[c] && !m_prev[c]) begin
               m_run[c] = 1;
            end
            m_prev[c] = en_i[c];
            if ((e_sh[c] || e_lg[c]) && e_cnt[c] < (1 << CNT_W) - 1)
               e_cnt[c] = e_cnt[c] + 1;
            if (e_sh[c])               e_ss[c] = STK;
            else if (sticky_clr_i[c])  e_ss[c] = 1'b0;
            if (e_lg[c])               e_sl[c] = STK;
            else if (sticky_clr_i[c])  e_sl[c] = 1'b0;
         end
      end
   end

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [NCH*WID_W-1:0] ew;
      logic [NCH*CNT_W-1:0] ec;
      for (int c = 0; c < NCH; c++) begin
         ew[c*WID_W +: WID_W] = WID_W'(e_wid[c]);
         ec[c*CNT_W +: CNT_W] = CNT_W'(e_cnt[c]);
      end
      cmp("model ok_o",           64'(ok_o),           64'(e_ok));
      cmp("model short_err_o",    64'(short_err_o),    64'(e_sh));
      cmp("model long_err_o",     64'(long_err_o),     64'(e_lg));
      cmp("model last_wid_o",     64'(last_wid_o),     64'(ew));
      cmp("model err_cnt_o",      64'(err_cnt_o),      64'(ec));
      cmp("model sticky_short_o", 64'(sticky_short_o), 64'(e_ss));
      cmp("model sticky_long_o",  64'(sticky_long_o),  64'(e_sl));
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic int fw(input int c);
      return int'(last_wid_o[c*WID_W +: WID_W]);
   endfunction

   function automatic int fc(input int c);
      return int'(err_cnt_o[c*CNT_W +: CNT_W]);
   endfunction

   initial begin
      rst          = 1'b1;
      en_i         = 4'b1000;
      chan_en_i    = '1;
      sticky_clr_i = '0;
      cyc(3);
      cmp("reset flags",   64'({ok_o, short_err_o, long_err_o}), 64'd0);
      cmp("reset wid/cnt", 64'({last_wid_o, err_cnt_o}), 64'd0);

      // ch3 already high at reset release: ignored
      rst = 1'b0;
      cyc(10);
      en_i[3] = 1'b0;
      cyc(2);
      cmp("ch3 pre-high no flag", 64'({ok_o[3], short_err_o[3], long_err_o[3]}), 64'd0);
      cmp("ch3 pre-high wid", 64'(fw(3)), 64'd0);
      en_i[3] = 1'b1; cyc(16); en_i[3] = 1'b0; cyc(1);
      cmp("ch3 ok", 64'(ok_o[3]), 64'd1);
      cmp("ch3 wid", 64'(fw(3)), 64'd16);

      // ch0 exact 16
      en_i[0] = 1'b1; cyc(16);
      cmp("ch0 ok not early", 64'(ok_o[0]), 64'd0);
      en_i[0] = 1'b0; cyc(1);
      cmp("ch0 ok", 64'(ok_o[0]), 64'd1);
      cmp("ch0 wid", 64'(fw(0)), 64'd16);
      cmp("ch0 cnt", 64'(fc(0)), 64'd0);
      cyc(1);
      cmp("ch0 ok one cycle", 64'(ok_o[0]), 64'd0);

      // ch1 short 5
      en_i[1] = 1'b1; cyc(5); en_i[1] = 1'b0; cyc(1);
      cmp("ch1 short", 64'(short_err_o[1]), 64'd1);
      cmp("ch1 wid", 64'(fw(1)), 64'd5);
      cmp("ch1 cnt", 64'(fc(1)), 64'd1);

      // ch2 held 40 cycles
      en_i[2] = 1'b1; cyc(16);
      cmp("ch2 long not early", 64'(long_err_o[2]), 64'd0);
      cyc(1);
      cmp("ch2 long", 64'(long_err_o[2]), 64'd1);
      cmp("ch2 wid", 64'(fw(2)), 64'd17);
      cmp("ch2 cnt", 64'(fc(2)), 64'd1);
      cyc(1);
      cmp("ch2 long once", 64'(long_err_o[2]), 64'd0);
      cyc(22); en_i[2] = 1'b0; cyc(1);
      cmp("ch2 no flag at fall", 64'({ok_o[2], short_err_o[2], long_err_o[2]}), 64'd0);
      cmp("ch2 cnt kept", 64'(fc(2)), 64'd1);
      cyc(1);

      // simultaneous end on ch0 (ok) and ch1 (short)
      en_i[0] = 1'b1; cyc(13); en_i[1] = 1'b1; cyc(3); en_i[1:0] = 2'b00; cyc(1);
      cmp("simul ok0/short1", 64'({ok_o[0], short_err_o[1]}), 64'b11);

      // back-to-back on ch0
      en_i[0] = 1'b1; cyc(16); en_i[0] = 1'b0; cyc(1);
      cmp("b2b first ok", 64'(ok_o[0]), 64'd1);
      en_i[0] = 1'b1; cyc(16); en_i[0] = 1'b0; cyc(1);
      cmp("b2b second ok", 64'(ok_o[0]), 64'd1);

      // chan_en dropped mid-pulse, re-enabled while high
      en_i[0] = 1'b1; cyc(8); chan_en_i[0] = 1'b0; cyc(3); chan_en_i[0] = 1'b1; cyc(10);
      en_i[0] = 1'b0; cyc(1);
      cmp("chan_en drop no flag", 64'({ok_o[0], short_err_o[0], long_err_o[0]}), 64'd0);
      cmp("chan_en drop wid", 64'(fw(0)), 64'd16);
      cmp("chan_en drop cnt", 64'(fc(0)), 64'd0);
      en_i[0] = 1'b1; cyc(4); en_i[0] = 1'b0; cyc(1);
      cmp("ch0 recovered short", 64'(short_err_o[0]), 64'd1);

      // long on ch0 for the sticky long flag
      en_i[0] = 1'b1; cyc(20); en_i[0] = 1'b0; cyc(2);
      cmp("ch0 sticky long", 64'(sticky_long_o[0]), 64'(STK));

      // sticky clear, then same-cycle set/clear on ch1
      cmp("ch1 sticky short set", 64'(sticky_short_o[1]), 64'(STK));
      sticky_clr_i[1] = 1'b1; cyc(1); sticky_clr_i[1] = 1'b0;
      cmp("ch1 sticky cleared", 64'(sticky_short_o[1]), 64'd0);
      en_i[1] = 1'b1; cyc(2); en_i[1] = 1'b0; sticky_clr_i[1] = 1'b1; cyc(1);
      cmp("sticky set wins", 64'(sticky_short_o[1]), 64'(STK));
      cyc(1); sticky_clr_i[1] = 1'b0;
      cmp("sticky clr after", 64'(sticky_short_o[1]), 64'd0);

      // reset mid-pulse on ch1
      en_i[1] = 1'b1; cyc(3);
      #1 rst = 1'b1;
      #3 rst = 1'b0;
      cmp("mid reset cnt", 64'(err_cnt_o), 64'd0);
      cyc(4); en_i[1] = 1'b0; cyc(1);
      cmp("mid reset no flag", 64'({ok_o[1], short_err_o[1]}), 64'd0);
      cyc(1);

      // 300 short pulses saturate ch1 error counter
      repeat (300) begin
         en_i[1] = 1'b1; cyc(1); en_i[1] = 1'b0; cyc(1);
      end
      cyc(1);
      cmp("ch1 cnt saturated", 64'(fc(1)), 64'd255);
      cmp("ch1 wid after sat", 64'(fw(1)), 64'd1);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
